// File: rtl/spi_transfer_scheduler_pkg.sv
// Shared types and helpers for the two-requester SPI transfer scheduler.
package spi_transfer_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    localparam int CPOL_BIT = 1;
    localparam int CPHA_BIT = 0;

    function automatic int cs_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_width(input int d);
        return $clog2(d + 1);
    endfunction

endpackage

// File: rtl/spi_transfer_scheduler_shift_engine.sv
// Bit sequencer: sclk toggles, pico drive and poci capture for one byte.
module spi_shift_engine
    import spi_transfer_scheduler_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic       load_cpol,
    input  logic       start,
    input  logic       cpha,
    input  logic [7:0] tx,
    input  logic       poci,
    output logic       sclk,
    output logic       pico,
    output logic [7:0] rx,
    output logic       shift_end,
    output logic       done
);

    localparam int CNT_W = cnt_width(CLK_DIV);

    logic             active;
    logic [CNT_W-1:0] cnt;
    logic [4:0]       tog;
    logic [4:0]       nxt;
    logic [7:0]       sh;
    logic             tick;
    logic             sample;
    logic             last;

    assign tick      = active && (cnt == CNT_W'(CLK_DIV));
    assign nxt       = tog + 5'd1;
    assign last      = (nxt == 5'd16);
    // odd toggles are leading edges; CPHA picks which edge samples
    assign sample    = nxt[0] ^ cpha;
    assign shift_end = tick && last;
    assign done      = tick && (tog == 5'd16);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            active <= 1'b0;
            cnt    <= '0;
            tog    <= '0;
            sh     <= '0;
            rx     <= '0;
            sclk   <= 1'b0;
            pico   <= 1'b0;
        end else begin
            if (load) sclk <= load_cpol;
            if (start) begin
                active <= 1'b1;
                cnt    <= CNT_W'(1);
                tog    <= '0;
                rx     <= '0;
                pico   <= cpha ? 1'b0 : tx[7];
                sh     <= cpha ? tx : {tx[6:0], 1'b0};
            end else if (active) begin
                if (!tick) begin
                    cnt <= cnt + CNT_W'(1);
                end else begin
                    cnt <= CNT_W'(1);
                    if (done) begin
                        active <= 1'b0;
                        pico   <= 1'b0;
                    end else begin
                        tog  <= nxt;
                        sclk <= ~sclk;
                        if (sample) begin
                            rx <= {rx[6:0], poci};
                        end else if (!last) begin
                            pico <= sh[7];
                            sh   <= {sh[6:0], 1'b0};
                        end
                    end
                end
            end
        end
    end

endmodule

// File: rtl/spi_transfer_scheduler.sv
// Round-robin arbiter and transfer sequencer for a shared SPI bus.
module spi_transfer_scheduler
    import spi_transfer_scheduler_pkg::*;
#(
    parameter int NUM_CS  = 2,
    parameter int CLK_DIV = 4,
    parameter int CS_W    = cs_width(NUM_CS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [2*CS_W-1:0] req_cs,
    input  logic [3:0]        req_mode,
    input  logic [15:0]       req_data,
    output logic              rsp_valid,
    output logic              rsp_id,
    output logic [7:0]        rsp_data,
    output logic              sclk,
    output logic              pico,
    input  logic              poci,
    output logic [NUM_CS-1:0] cs
);

    localparam int CNT_W = cnt_width(CLK_DIV);

    state_t           state;
    logic             ptr;
    logic             id_q;
    logic [CS_W-1:0]  cs_q;
    logic             cpha_q;
    logic [7:0]       tx_q;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             acc_id;
    logic [CS_W-1:0]  sel_cs;
    logic [1:0]       sel_mode;
    logic [7:0]       sel_data;
    logic [NUM_CS-1:0] cs_dec;
    logic             cs_ok;
    logic             start;
    logic             shift_end;
    logic             done;
    logic [7:0]       rx;

    always_comb begin
        req_ready = '0;
        if (state == ST_IDLE) begin
            if (req_valid[ptr]) req_ready[ptr] = 1'b1;
            else if (req_valid[~ptr]) req_ready[~ptr] = 1'b1;
        end
    end

    assign accept   = |(req_valid & req_ready);
    assign acc_id   = req_ready[1];
    assign sel_cs   = acc_id ? req_cs[CS_W +: CS_W] : req_cs[0 +: CS_W];
    assign sel_mode = acc_id ? req_mode[3:2] : req_mode[1:0];
    assign sel_data = acc_id ? req_data[15:8] : req_data[7:0];
    assign start    = (state == ST_SETUP) && (cnt == CNT_W'(CLK_DIV));
    assign cs_ok    = int'(cs_q) < NUM_CS;

    // out-of-range index selects no line
    always_comb begin
        cs_dec = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (cs_q == CS_W'(i)) cs_dec[i] = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            ptr       <= 1'b0;
            id_q      <= 1'b0;
            cs_q      <= '0;
            cpha_q    <= 1'b0;
            tx_q      <= '0;
            cnt       <= '0;
            cs        <= '1;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        id_q   <= acc_id;
                        cs_q   <= sel_cs;
                        cpha_q <= sel_mode[CPHA_BIT];
                        tx_q   <= sel_data;
                        ptr    <= ~acc_id;
                        cnt    <= '0;
                        state  <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (start) begin
                        cs    <= cs_dec;
                        state <= ST_SHIFT;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_SHIFT: begin
                    if (shift_end) state <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (done) begin
                        cs        <= '1;
                        rsp_valid <= 1'b1;
                        rsp_id    <= id_q;
                        rsp_data  <= cs_ok ? rx : 8'h00;
                        state     <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    spi_shift_engine #(
        .CLK_DIV(CLK_DIV)
    ) u_engine (
        .clock    (clock),
        .reset    (reset),
        .load     (accept),
        .load_cpol(sel_mode[CPOL_BIT]),
        .start    (start),
        .cpha     (cpha_q),
        .tx       (tx_q),
        .poci     (poci),
        .sclk     (sclk),
        .pico     (pico),
        .rx       (rx),
        .shift_end(shift_end),
        .done     (done)
    );

endmodule

// File: doc/spi_transfer_scheduler.md
# spi_transfer_scheduler

Two-requester SPI manager that arbitrates a single SPI bus (sclk/pico/poci/cs) between two on-chip requesters and sequences complete 8-bit full-duplex transfers in any of SPI modes 0–3, per transfer. It sits between bus-side agents and the external SPI pins, replacing software bit-sequencing. Chip select, mode and TX byte are supplied per request; the received byte is returned tagged with the requester id.

## Interface
- `NUM_CS`, 2, number of active-low chip-select lines (≥1).
- `CLK_DIV`, 4, sclk half-period in `clock` cycles (≥1).
- `CS_W`, max(1, $clog2(NUM_CS)), derived width of a chip-select index.

Ports:
- `clock`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  2  per-requester request valid; bit i = requester i.
- `req_ready`  out  2  per-requester accept; a transfer is accepted on `req_valid[i] && req_ready[i]`.
- `req_cs`  in  2*CS_W  chip-select index; requester i uses slice [i*CS_W +: CS_W].
- `req_mode`  in  4  SPI mode; slice [i*2 +: 2] = {CPOL, CPHA}.
- `req_data`  in  16  TX byte; slice [i*8 +: 8].
- `rsp_valid`  out  1  one-cycle pulse: transfer complete.
- `rsp_id`  out  1  requester id of the completed transfer.
- `rsp_data`  out  8  received byte; valid with `rsp_valid`.
- `sclk`  out  1  SPI clock.
- `pico`  out  1  serial data to peripheral.
- `poci`  in  1  serial data from peripheral.
- `cs`  out  NUM_CS  active-low chip selects.

## Operation
- States: IDLE → SETUP → SHIFT → HOLD → IDLE.
- IDLE: `req_ready` is combinational from state, round-robin pointer `ptr` and `req_valid`: if `req_valid[ptr]`, ready only for `ptr`; else if the other requester is valid, ready only for it. At most one ready bit is high; requesters must not make valid depend on ready.
- On accept: latch id, cs index, mode, TX byte; `ptr` ← complement of the accepted id.
- SETUP: all `cs` high; `sclk` driven to new CPOL. CPOL changes only while every `cs` is high.
- SHIFT: selected `cs` low; 16 sclk toggles. CPHA=0: `pico`=bit7 at cs fall, next bit driven on each trailing edge (toggles 2,4,…,14); sample `poci` on leading edges (1,3,…,15). CPHA=1: drive bits on leading edges (bit7 at toggle 1); sample on trailing edges (2,…,16).
- Sampling: `poci` captured at the clock edge that produces the sampling sclk transition; MSB first into the RX shift register.
- HOLD: `cs` low, `sclk`=CPOL for `CLK_DIV` cycles, then `cs` high, `rsp_valid` pulses.
- `req_cs` ≥ NUM_CS: timing unchanged, no `cs` line asserted, `rsp_data` forced to 8'h00.
- Reset (any state): `cs` all ones, `sclk` 0, `pico` 0, `rsp_valid` 0, `rsp_id` 0, `rsp_data` 0, `req_ready` 0 by state, `ptr` 0, state IDLE. Mid-transfer reset drops the transfer; no response.
- `pico` is 0 outside SHIFT/HOLD; `sclk` holds the last CPOL in IDLE.

## Timing
- Accept at edge T; D = `CLK_DIV`. SETUP occupies T+1..T+D.
- `cs` falls at S = T+D+1; sclk toggle k (1..16) at S+k·D.
- `cs` rises and `rsp_valid` pulses at S+17·D = T+18·D+1.
- Earliest next accept: the cycle after `rsp_valid`. Sustained throughput: one byte per 18·D+2 cycles.
- `rsp_id`/`rsp_data` hold until the next `rsp_valid`.

## Structure
- Shared header: state encoding localparams, mode bit positions (CPOL=1, CPHA=0), `CS_W` derivation.
- Sub-module `spi_shift_engine`: half-period counter, toggle counter, sclk/pico/RX shift, given latched mode/byte and a start strobe; returns done. Top level holds arbiter, request latches, cs decode, response regs.

## Test plan
- Mode 0, D=2, requester 0 sends 0xA5 then 0x3C to cs0 with an echo-previous-byte mode-0/3 model -> second `rsp_data` = 0xA5; 8 rising sclk edges per transfer; `rsp_valid` at T+37.
- Both `req_valid` asserted at same cycle after reset -> requester 0 served first, then 1; `rsp_id` sequence 0,1; `ptr` alternates on a third simultaneous pair.
- Mode 0 transfer then mode 2 to cs1 (mode-1/2 echo model) -> `sclk` goes 1 only while `cs`=2'b11; cs1 echo returns previous cs1 byte.
- Reset asserted at toggle 7 of SHIFT -> `cs` = all ones immediately, `sclk`=0, no `rsp_valid`; next request completes normally.
- NUM_CS=3, `req_cs`=3 -> `cs` stays 3'b111 throughout, `rsp_valid` at T+18·D+1, `rsp_data`=0x00.
- D=1, mode 3, 0xFF -> sclk period 2 cycles, `rsp_valid` at T+19.
